// File: rtl/note_seq_pkg.sv
// note_seq_pkg: shared types and helpers for the note sequencer.
// Holds the sequencer state enum, the requester count and index type,
// and a counter-width helper used to size the prescaler and gap counters.
package note_seq_pkg;

  localparam int NUM_REQ = 2;

  // Index of one requester (NUM_REQ = 2, so a single bit).
  typedef logic [0:0] req_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Width needed to hold counts 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/note_sequencer_tone_gen.sv
// tone_gen: square-wave generator for one note.
// Ports: CLK, RST (async, active-high); en counts this cycle; restart clears the
// counter and output (wins over en); half = half-period in clocks (0 = rest); SPEAKER = tone.
module tone_gen #(
  parameter int PERIOD_W = 22
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                en,
  input  logic                restart,
  input  logic [PERIOD_W-1:0] half,
  output logic                SPEAKER
);

  logic [PERIOD_W-1:0] cnt;

  // The counter only ever reaches half-1, so it never wraps.
  // half == 0 is a rest: the output is held low and the counter stays at 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt     <= '0;
      SPEAKER <= 1'b0;
    end else if (restart) begin
      cnt     <= '0;
      SPEAKER <= 1'b0;
    end else if (en && (half != '0)) begin
      if (cnt == half - PERIOD_W'(1)) begin
        cnt     <= '0;
        SPEAKER <= ~SPEAKER;
      end else begin
        cnt <= cnt + PERIOD_W'(1);
      end
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: arbitrates notes from two requesters and plays each as a timed
// square wave followed by a silent gap. Ports: CLK, RST (async, active-high); per-requester
// REQ_VALID/REQ_READY/REQ_PERIOD/REQ_DUR; SPEAKER, BUSY, GRANT (one-hot), NOTE_DONE.
// Define NOTE_SEQ_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int PERIOD_W   = 22,
  parameter int DUR_W      = 16,
  parameter int GAP_CYCLES = 500_000
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_REQ-1:0]          REQ_VALID,
  output logic [NUM_REQ-1:0]          REQ_READY,
  input  logic [NUM_REQ*PERIOD_W-1:0] REQ_PERIOD,
  input  logic [NUM_REQ*DUR_W-1:0]    REQ_DUR,
  output logic                        SPEAKER,
  output logic                        BUSY,
  output logic [NUM_REQ-1:0]          GRANT,
  output logic                        NOTE_DONE
);

  // CLK_HZ must be at least 1000 so that one millisecond is at least one clock.
  localparam int MS_CYCLES = CLK_HZ / 1000;
  localparam int GAP_EFF   = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam int PRE_W     = cnt_w(MS_CYCLES);
  localparam int GAP_W     = cnt_w(GAP_EFF);

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(MS_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_EFF - 1);

  state_t              state;
  logic [PERIOD_W-1:0] half_q;
  logic [DUR_W-1:0]    rem_ms;
  logic [PRE_W-1:0]    pre_cnt;
  logic [GAP_W-1:0]    gap_cnt;

  req_idx_t            pick;
  logic                any_vld;
  logic                accept;
  logic                play_end;
  logic [PERIOD_W-1:0] sel_half;
  logic [DUR_W-1:0]    sel_dur;

  // ---------------------------------------------------------------------------
  // Arbiter
  // ---------------------------------------------------------------------------
`ifdef NOTE_SEQ_RR_EN
  // Last requester granted; reset to 1 so requester 0 wins the first contest.
  req_idx_t last_idx;

  always_comb begin
    any_vld = |REQ_VALID;
    if (&REQ_VALID) begin
      pick = ~last_idx;
    end else begin
      pick = REQ_VALID[0] ? req_idx_t'(0) : req_idx_t'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_idx <= req_idx_t'(1);
    end else if (accept) begin
      last_idx <= pick;
    end
  end
`else
  always_comb begin
    any_vld = |REQ_VALID;
    pick    = REQ_VALID[0] ? req_idx_t'(0) : req_idx_t'(1);
  end
`endif

  // Ready is offered only in IDLE and never while reset is asserted, so a
  // requester cannot see a handshake that the reset flops would then ignore.
  always_comb begin
    REQ_READY = '0;
    if (!RST && (state == IDLE) && any_vld) begin
      REQ_READY = NUM_REQ'(1) << pick;
    end
  end

  assign accept = |(REQ_VALID & REQ_READY);

  assign sel_half = pick[0] ? REQ_PERIOD[PERIOD_W +: PERIOD_W] : REQ_PERIOD[0 +: PERIOD_W];
  assign sel_dur  = pick[0] ? REQ_DUR[DUR_W +: DUR_W]          : REQ_DUR[0 +: DUR_W];

  // Last PLAY cycle: final prescaler tick of the final millisecond.
  assign play_end = (state == PLAY) && (pre_cnt == PRE_MAX) && (rem_ms == DUR_W'(1));

  // ---------------------------------------------------------------------------
  // Sequencer FSM, duration and gap counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      half_q    <= '0;
      rem_ms    <= '0;
      pre_cnt   <= '0;
      gap_cnt   <= '0;
      BUSY      <= 1'b0;
      GRANT     <= '0;
      NOTE_DONE <= 1'b0;
    end else begin
      NOTE_DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            GRANT   <= REQ_READY;
            BUSY    <= 1'b1;
            half_q  <= sel_half;
            rem_ms  <= sel_dur;
            pre_cnt <= '0;
            gap_cnt <= '0;
            if (sel_dur == '0) begin
              state     <= GAP;
              NOTE_DONE <= 1'b1;
            end else begin
              state <= PLAY;
            end
          end
        end

        PLAY: begin
          if (pre_cnt == PRE_MAX) begin
            pre_cnt <= '0;
            rem_ms  <= rem_ms - DUR_W'(1);
            if (rem_ms == DUR_W'(1)) begin
              state     <= GAP;
              NOTE_DONE <= 1'b1;
            end
          end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
          end
        end

        GAP: begin
          if (gap_cnt == GAP_MAX) begin
            state <= IDLE;
            BUSY  <= 1'b0;
            GRANT <= '0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
          GRANT <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Tone datapath
  // ---------------------------------------------------------------------------
  // Restarting on the last PLAY edge forces SPEAKER low for the whole gap.
  tone_gen #(
    .PERIOD_W (PERIOD_W)
  ) u_tone (
    .CLK     (CLK),
    .RST     (RST),
    .en      (state == PLAY),
    .restart (accept || play_end),
    .half    (half_q),
    .SPEAKER (SPEAKER)
  );

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed bench for note_sequencer with CLK_HZ=4000 (4 clocks/ms)
// and GAP_CYCLES=3. Each comparison goes through check(); expected values are
// hand-computed constants. Grant order in the contention test follows NOTE_SEQ_RR_EN.
module tb_note_sequencer;

  localparam int PW = 8;
  localparam int DW = 8;

  logic          CLK;
  logic          RST;
  logic [1:0]    REQ_VALID;
  logic [1:0]    REQ_READY;
  logic [2*PW-1:0] REQ_PERIOD;
  logic [2*DW-1:0] REQ_DUR;
  logic          SPEAKER;
  logic          BUSY;
  logic [1:0]    GRANT;
  logic          NOTE_DONE;

  int n_chk  = 0;
  int n_pass = 0;

  note_sequencer #(
    .CLK_HZ     (4000),
    .PERIOD_W   (PW),
    .DUR_W      (DW),
    .GAP_CYCLES (3)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .REQ_VALID  (REQ_VALID),
    .REQ_READY  (REQ_READY),
    .REQ_PERIOD (REQ_PERIOD),
    .REQ_DUR    (REQ_DUR),
    .SPEAKER    (SPEAKER),
    .BUSY       (BUSY),
    .GRANT      (GRANT),
    .NOTE_DONE  (NOTE_DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Starting in the first cycle after an accept edge, step until BUSY drops
  // (bounded), recording SPEAKER per cycle and NOTE_DONE pulses.
  task automatic measure(output int busy, output int done_at, output int done_n,
                         output logic [31:0] spk);
    busy = 0; done_at = -1; done_n = 0; spk = '0;
    while (BUSY && busy < 200) begin
      if (busy < 32) spk[busy] = SPEAKER;
      if (NOTE_DONE) begin
        done_n++;
        if (done_at < 0) done_at = busy;
      end
      busy++;
      tick();
    end
  endtask

  int          busy, done_at, done_n;
  logic [31:0] spk;
  logic [1:0]  exp_g [3];
  logic [1:0]  rdy_seen;
  logic        busy_seen;

  initial begin
`ifdef NOTE_SEQ_RR_EN
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
`else
    exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01;
`endif
    RST = 1'b1; REQ_VALID = 2'b01; REQ_PERIOD = '0; REQ_DUR = '0;
    #1;
    // Reset state
    check("rst_ready",  32'(REQ_READY), 32'h0);
    tick(); tick();
    check("rst_busy",   32'(BUSY),      32'h0);
    check("rst_grant",  32'(GRANT),     32'h0);
    check("rst_spk",    32'(SPEAKER),   32'h0);
    check("rst_done",   32'(NOTE_DONE), 32'h0);
    REQ_VALID = 2'b00;
    RST = 1'b0;
    tick();

    // 1. Single note: req0 half=2 dur=3
    REQ_VALID = 2'b01; REQ_PERIOD[7:0] = 8'd2; REQ_DUR[7:0] = 8'd3;
    #1;
    check("t1_ready", 32'(REQ_READY), 32'h1);
    tick();
    REQ_VALID = 2'b00;
    check("t1_grant", 32'(GRANT), 32'h1);
    measure(busy, done_at, done_n, spk);
    check("t1_busy",    32'(busy),    32'd15);
    check("t1_spk",     spk,          32'h0CCC);
    check("t1_done_n",  32'(done_n),  32'd1);
    check("t1_done_at", 32'(done_at), 32'd12);
    check("t1_idle_grant", 32'(GRANT), 32'h0);

    // 2. Rest: req1 half=0 dur=2
    REQ_VALID = 2'b10; REQ_PERIOD[15:8] = 8'd0; REQ_DUR[15:8] = 8'd2;
    #1;
    check("t2_ready", 32'(REQ_READY), 32'h2);
    tick();
    REQ_VALID = 2'b00;
    check("t2_grant", 32'(GRANT), 32'h2);
    measure(busy, done_at, done_n, spk);
    check("t2_busy",    32'(busy),    32'd11);
    check("t2_spk",     spk,          32'h0);
    check("t2_done_at", 32'(done_at), 32'd8);

    // 3. Contention: both valid, three notes of dur=1
    REQ_VALID = 2'b11;
    REQ_PERIOD = {8'd1, 8'd1}; REQ_DUR = {8'd1, 8'd1};
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("t3_ready%0d", k), 32'(REQ_READY), 32'(exp_g[k]));
      tick();
      check($sformatf("t3_grant%0d", k), 32'(GRANT), 32'(exp_g[k]));
      measure(busy, done_at, done_n, spk);
      check($sformatf("t3_busy%0d", k), 32'(busy), 32'd7);
    end
    REQ_VALID = 2'b00;
    tick();

    // 4. Zero duration on req0
    REQ_VALID = 2'b01; REQ_PERIOD[7:0] = 8'd2; REQ_DUR[7:0] = 8'd0;
    tick();
    REQ_VALID = 2'b00;
    measure(busy, done_at, done_n, spk);
    check("t4_busy",    32'(busy),    32'd3);
    check("t4_done_at", 32'(done_at), 32'd0);
    check("t4_done_n",  32'(done_n),  32'd1);
    check("t4_spk",     spk,          32'h0);

    // 5. Reset mid-PLAY, req0 stays valid
    REQ_VALID = 2'b01; REQ_PERIOD[7:0] = 8'd2; REQ_DUR[7:0] = 8'd3;
    tick();
    tick(); tick(); tick();
    check("t5_pre_spk", 32'(SPEAKER), 32'h1);
    #2 RST = 1'b1;
    #1;
    check("t5_rst_spk",   32'(SPEAKER),   32'h0);
    check("t5_rst_busy",  32'(BUSY),      32'h0);
    check("t5_rst_grant", 32'(GRANT),     32'h0);
    check("t5_rst_ready", 32'(REQ_READY), 32'h0);
    #2 RST = 1'b0;
    #1;
    check("t5_rel_ready", 32'(REQ_READY), 32'h1);
    tick();
    REQ_VALID = 2'b00;
    check("t5_acc_busy",  32'(BUSY),  32'h1);
    check("t5_acc_grant", 32'(GRANT), 32'h1);
    measure(busy, done_at, done_n, spk);
    check("t5_busy", 32'(busy), 32'd15);

    // 6. req1 pulses VALID during a req0 note
    REQ_VALID = 2'b01; REQ_PERIOD = {8'd3, 8'd1}; REQ_DUR = {8'd5, 8'd2};
    tick();
    REQ_VALID = 2'b00;
    rdy_seen = 2'b00;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) REQ_VALID = 2'b10;
      if (i == 5) REQ_VALID = 2'b00;
      #1;
      rdy_seen = rdy_seen | REQ_READY;
      tick();
    end
    check("t6_ready", 32'(rdy_seen), 32'h0);
    measure(busy, done_at, done_n, spk);
    check("t6_busy_rest", 32'(busy), 32'd3);
    busy_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      busy_seen = busy_seen | BUSY;
      tick();
    end
    check("t6_no_replay", 32'(busy_seen), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
